// File: rtl/and_gate_3_if.sv
// Signal bundle for and_gate_3: the three AND inputs and every derived status output.
// The slave modport is the gate; the master modport is whatever drives the inputs and observes s.
interface and_gate_3_if #(
    parameter int CNT_W = 16
);
    logic             x;
    logic             y;
    logic             z;
    logic             s;
    logic             s_q;
    logic             s_rise;
    logic             s_fall;
    logic [CNT_W-1:0] high_cnt;
    logic             cnt_sat;

    modport master (
        output x, y, z,
        input  s, s_q, s_rise, s_fall, high_cnt, cnt_sat
    );

    modport slave (
        input  x, y, z,
        output s, s_q, s_rise, s_fall, high_cnt, cnt_sat
    );
endinterface

// File: rtl/and_gate_3.sv
// 3-input AND with registered copy, edge pulses and a saturating high-cycle counter.
// Optional macro AND_GATE3_SYNC_EN: 2-flop synchronizers on x/y/z ahead of the registered path.
module and_gate_3 #(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    and_gate_3_if.slave  bus
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    logic             s_in;
    logic             s_q_p0;
    logic             s_rise_p0;
    logic             s_fall_p0;
    logic [CNT_W-1:0] high_cnt_p0;

    // The combinational output never passes through the synchronizers.
    assign bus.s = bus.x & bus.y & bus.z;

`ifdef AND_GATE3_SYNC_EN
    logic [2:0] xyz_p0;
    logic [2:0] xyz_p1;

    // Synchronizer stages, each input handled independently before the AND.
    always_ff @(posedge clk) begin
        if (rst) begin
            xyz_p0 <= 3'b000;
            xyz_p1 <= 3'b000;
        end else begin
            xyz_p0 <= {bus.x, bus.y, bus.z};
            xyz_p1 <= xyz_p0;
        end
    end

    assign s_in = &xyz_p1;
`else
    assign s_in = bus.s;
`endif

    // Registered stage: level, edges and counter all advance on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q_p0      <= 1'b0;
            s_rise_p0   <= 1'b0;
            s_fall_p0   <= 1'b0;
            high_cnt_p0 <= '0;
        end else begin
            s_q_p0    <= s_in;
            s_rise_p0 <= s_in & ~s_q_p0;
            s_fall_p0 <= ~s_in & s_q_p0;
            if (s_q_p0) begin
                high_cnt_p0 <= sat_inc(high_cnt_p0);
            end
        end
    end

    assign bus.s_q      = s_q_p0;
    assign bus.s_rise   = s_rise_p0;
    assign bus.s_fall   = s_fall_p0;
    assign bus.high_cnt = high_cnt_p0;
    assign bus.cnt_sat  = (high_cnt_p0 == {CNT_W{1'b1}});

endmodule

// File: tb/tb_and_gate_3.sv
// Directed bench for and_gate_3 (CNT_W=4 so saturation is reachable quickly).
`timescale 1ns/1ps
module tb_and_gate_3;

    localparam int CNT_W = 4;
`ifdef AND_GATE3_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    and_gate_3_if #(.CNT_W(CNT_W)) bus ();

    and_gate_3 #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_in(input logic [2:0] v);
        bus.x = v[2];
        bus.y = v[1];
        bus.z = v[0];
    endtask

    task automatic regs(input string tag, input logic q, input logic r, input logic f,
                        input int cnt, input logic sat);
        chk({tag, "_s_q"},      32'(bus.s_q),      32'(q));
        chk({tag, "_s_rise"},   32'(bus.s_rise),   32'(r));
        chk({tag, "_s_fall"},   32'(bus.s_fall),   32'(f));
        chk({tag, "_high_cnt"}, 32'(bus.high_cnt), 32'(cnt));
        chk({tag, "_cnt_sat"},  32'(bus.cnt_sat),  32'(sat));
    endtask

    logic [2:0] tt_in  [6];
    logic       tt_exp [6];

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        set_in(3'b000);

        // Truth table, s sampled 1 ps after each change.
        tt_in  = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b011, 3'b001};
        tt_exp = '{1'b0,   1'b0,   1'b0,   1'b1,   1'b0,   1'b0};
        for (int i = 0; i < 6; i++) begin
            set_in(tt_in[i]);
            #0.001;
            chk($sformatf("truth_%03b", tt_in[i]), 32'(bus.s), 32'(tt_exp[i]));
            #19.999;
        end

        // Reset held with all inputs high.
        step(1);
        set_in(3'b111);
        step(2);
        chk("rst_s", 32'(bus.s), 32'd1);
        regs("rst", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        rst = 1'b0;
        step(LAT);
        regs("rel", 1'b1, 1'b1, 1'b0, 0, 1'b0);
        step(1);
        regs("rel2", 1'b1, 1'b0, 1'b0, 1, 1'b0);

        // Edges: rise, five high cycles, fall, then hold.
        rst = 1'b1;
        set_in(3'b000);
        step(1);
        rst = 1'b0;
        set_in(3'b111);
        step(LAT);
        regs("edge_rise", 1'b1, 1'b1, 1'b0, 0, 1'b0);
        step(4);
        regs("edge_hold", 1'b1, 1'b0, 1'b0, 4, 1'b0);
        set_in(3'b011);
        step(LAT);
        regs("edge_fall", 1'b0, 1'b0, 1'b1, 4 + LAT, 1'b0);
        step(2);
        regs("edge_after", 1'b0, 1'b0, 1'b0, 4 + LAT, 1'b0);

        // Saturation at 15 with CNT_W=4.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        set_in(3'b111);
        step(LAT + 14);
        regs("sat14", 1'b1, 1'b0, 1'b0, 14, 1'b0);
        step(1);
        regs("sat15", 1'b1, 1'b0, 1'b0, 15, 1'b1);
        step(5);
        regs("sat_hold", 1'b1, 1'b0, 1'b0, 15, 1'b1);

        // Mid-run reset while high_cnt=7, inputs kept high.
        rst = 1'b1;
        set_in(3'b000);
        step(1);
        rst = 1'b0;
        set_in(3'b111);
        step(LAT + 7);
        regs("mid_pre", 1'b1, 1'b0, 1'b0, 7, 1'b0);
        rst = 1'b1;
        step(1);
        regs("mid_rst", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        rst = 1'b0;
        step(LAT);
        regs("mid_rel", 1'b1, 1'b1, 1'b0, 0, 1'b0);
        step(1);
        regs("mid_cnt", 1'b1, 1'b0, 1'b0, 1, 1'b0);

`ifdef AND_GATE3_SYNC_EN
        // Synchronized path: s immediate, s_q three edges later.
        rst = 1'b1;
        set_in(3'b000);
        step(1);
        rst = 1'b0;
        step(1);
        set_in(3'b111);
        #0.001;
        chk("sync_s", 32'(bus.s), 32'd1);
        step(2);
        chk("sync_q2", 32'(bus.s_q), 32'd0);
        step(1);
        chk("sync_q3", 32'(bus.s_q), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
